// File: rtl/snake_game_fsm.sv
// Snake game state engine: body shift register, direction latch, food placement and
// one-hot game-state flags for the VGA colour stage.
module snake_game_fsm #(
    parameter int unsigned WIN_LENGTH = 15,
    parameter logic [7:0]  START_LOC  = 8'h66,
    parameter logic [1:0]  START_DIR  = 2'd3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         BtnU,
    input  logic         BtnD,
    input  logic         BtnL,
    input  logic         BtnR,
    input  logic         Tick,
    input  logic [7:0]   Rand,
    output logic         Qi,
    output logic         Qc,
    output logic         Qp,
    output logic         Qw,
    output logic         Ql,
    output logic [7:0]   Food,
    output logic [3:0]   Length,
    output logic [127:0] Locations_Flat
);

    typedef enum logic [4:0] {
        StInit   = 5'b10000,
        StCreate = 5'b01000,
        StPlay   = 5'b00100,
        StWin    = 5'b00010,
        StLose   = 5'b00001
    } state_e;

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirDown  = 2'd1;
    localparam logic [1:0] DirLeft  = 2'd2;
    localparam logic [1:0] DirRight = 2'd3;

    state_e      state;
    logic [7:0]  seg [16];
    logic [1:0]  cur_dir;
    logic [1:0]  pend_dir;
    logic [7:0]  cand;

    logic        btn_ok;
    logic [1:0]  btn_dir;
    logic [7:0]  next_head;
    logic        wall;
    logic        eat;
    logic        hit;
    logic        cand_hit;
    logic [3:0]  hit_limit;
    logic [3:0]  new_len;
    logic [7:0]  seg_shift [16];

    // State encoding is one-hot, so the flags are the state register bits directly.
    assign {Qi, Qc, Qp, Qw, Ql} = state;

    always_comb begin
        if (BtnU)      btn_dir = DirUp;
        else if (BtnD) btn_dir = DirDown;
        else if (BtnL) btn_dir = DirLeft;
        else           btn_dir = DirRight;
        // Opposite direction differs only in bit 0 (U/D, L/R).
        btn_ok = (BtnU | BtnD | BtnL | BtnR) && (state != StWin) && (state != StLose) &&
                 !((Length > 4'd1) && (btn_dir == (cur_dir ^ 2'd1)));
    end

    always_comb begin
        next_head = seg[0];
        wall      = 1'b0;
        unique case (pend_dir)
            DirUp:    begin wall = (seg[0][7:4] == 4'd0);  next_head = seg[0] - 8'd16; end
            DirDown:  begin wall = (seg[0][7:4] == 4'd15); next_head = seg[0] + 8'd16; end
            DirLeft:  begin wall = (seg[0][3:0] == 4'd0);  next_head = seg[0] - 8'd1;  end
            default:  begin wall = (seg[0][3:0] == 4'd15); next_head = seg[0] + 8'd1;  end
        endcase

        eat       = (next_head == Food);
        // The tail cell is vacated on a plain move but stays occupied when growing.
        hit_limit = eat ? Length : Length - 4'd1;
        new_len   = eat ? Length + 4'd1 : Length;
        hit       = 1'b0;
        cand_hit  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if ((k < int'(hit_limit)) && (seg[k] == next_head)) hit = 1'b1;
            if ((k < int'(Length)) && (seg[k] == cand)) cand_hit = 1'b1;
            if (k < int'(new_len)) seg_shift[k] = (k == 0) ? next_head : seg[(k == 0) ? 0 : k - 1];
            else                   seg_shift[k] = 8'h00;
        end
    end

    always_comb begin
        Locations_Flat = '0;
        for (int k = 0; k < 16; k++) Locations_Flat[127 - 8 * k -: 8] = seg[k];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= StInit;
            Length   <= 4'd1;
            cur_dir  <= START_DIR;
            pend_dir <= START_DIR;
            Food     <= 8'h00;
            cand     <= 8'h00;
            for (int k = 0; k < 16; k++) seg[k] <= (k == 0) ? START_LOC : 8'h00;
        end else begin
            if (btn_ok) pend_dir <= btn_dir;
            unique case (state)
                StInit: begin
                    if (Start) begin
                        state <= StCreate;
                        cand  <= Rand;
                    end
                end
                StCreate: begin
                    if (cand_hit) begin
                        cand <= cand + 8'd1;
                    end else begin
                        Food  <= cand;
                        state <= StPlay;
                    end
                end
                StPlay: begin
                    if (Tick) begin
                        cur_dir <= pend_dir;
                        if (wall || hit) begin
                            state <= StLose;
                        end else begin
                            for (int k = 0; k < 16; k++) seg[k] <= seg_shift[k];
                            Length <= new_len;
                            if (eat) begin
                                state <= (new_len == 4'(WIN_LENGTH)) ? StWin : StCreate;
                                cand  <= Rand;
                            end
                        end
                    end
                end
                StWin, StLose: begin
                    if (Start) begin
                        state    <= StInit;
                        Length   <= 4'd1;
                        cur_dir  <= START_DIR;
                        pend_dir <= START_DIR;
                        for (int k = 0; k < 16; k++) seg[k] <= (k == 0) ? START_LOC : 8'h00;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule
